// File: rtl/i2c_master_engine_if.sv
// Command/response handshake and open-drain pad signals of the I2C bit engine.
// The engine connects through the slave modport; the front-end uses the master modport.
interface i2c_master_engine_if #(
    parameter int DIV_W = 16
);
    logic [DIV_W-1:0] clk_div;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [7:0]       cmd_wdata;
    logic             cmd_nack;
    logic             rsp_valid;
    logic [7:0]       rsp_rdata;
    logic             rsp_ack;
    logic             rsp_err;
    logic             busy;
    logic             sda_i;
    logic             sda_oe;
    logic             scl_i;
    logic             scl_oe;

    modport master (
        output clk_div, cmd_valid, cmd_op, cmd_wdata, cmd_nack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err, busy
    );

    modport slave (
        input  clk_div, cmd_valid, cmd_op, cmd_wdata, cmd_nack, sda_i, scl_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_ack, rsp_err, busy, sda_oe, scl_oe
    );
endinterface

// File: rtl/i2c_master_engine.sv
// Byte-oriented I2C master bit engine: START/STOP/WRITE/READ in four-quarter bit
// slots, open-drain SDA/SCL, slave clock stretching with timeout abort.
module i2c_master_engine #(
    parameter int DIV_W      = 16,
    parameter int TO_W       = 20,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    i2c_master_engine_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;
    localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_WRITE = 2'd2, OP_READ = 2'd3;

    state_t           r_state;
    logic [1:0]       r_q, r_op;
    logic [DIV_W-1:0] r_div, r_qcnt;
    logic [TO_W-1:0]  r_to;
    logic [3:0]       r_slot;
    logic [7:0]       r_sh, r_rdata;
    logic             r_nack, r_ack_cap, r_sda_oe, r_scl_oe;
    logic             r_rsp_valid, r_ack, r_err, r_busy;
    logic [1:0]       r_scl_s, r_sda_s;

    logic w_scl, w_sda, w_cnt_done, w_q1_wait, w_timeout;

    assign w_scl      = r_scl_s[1];
    assign w_sda      = r_sda_s[1];
    assign w_cnt_done = (r_qcnt == r_div);
    // Q1 may only end once SCL is really high, so a stretching slave holds us here.
    assign w_q1_wait  = STRETCH_EN && (r_q == 2'd1) && !w_scl;
    assign w_timeout  = w_cnt_done && w_q1_wait && (r_to == '1);

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_ack   = r_ack;
    assign bus.rsp_err   = r_err;
    assign bus.busy      = r_busy;
    assign bus.sda_oe    = r_sda_oe;
    assign bus.scl_oe    = r_scl_oe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_q         <= 2'd0;
            r_op        <= 2'd0;
            r_div       <= '0;
            r_qcnt      <= '0;
            r_to        <= '0;
            r_slot      <= 4'd0;
            r_sh        <= 8'd0;
            r_rdata     <= 8'd0;
            r_nack      <= 1'b0;
            r_ack_cap   <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_scl_s     <= 2'b11;
            r_sda_s     <= 2'b11;
        end else begin
            r_scl_s     <= {r_scl_s[0], bus.scl_i};
            r_sda_s     <= {r_sda_s[0], bus.sda_i};
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.cmd_valid) begin
                    r_op      <= bus.cmd_op;
                    r_sh      <= bus.cmd_wdata;
                    r_nack    <= bus.cmd_nack;
                    r_div     <= bus.clk_div;
                    r_q       <= 2'd0;
                    r_qcnt    <= '0;
                    r_to      <= '0;
                    r_slot    <= 4'd0;
                    r_ack_cap <= 1'b0;
                    if (bus.cmd_op == OP_START) begin
                        r_state  <= S_START;
                        r_sda_oe <= 1'b0;
                        r_scl_oe <= r_busy;
                    end else if (!r_busy) begin
                        // No bus ownership: answer at once, only data ops are errors.
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_err       <= (bus.cmd_op != OP_STOP);
                        r_ack       <= 1'b0;
                        r_rdata     <= 8'd0;
                    end else if (bus.cmd_op == OP_STOP) begin
                        r_state  <= S_STOP;
                        r_scl_oe <= 1'b1;
                        r_sda_oe <= 1'b1;
                    end else begin
                        r_state  <= S_BIT;
                        r_scl_oe <= 1'b1;
                        r_sda_oe <= (bus.cmd_op == OP_WRITE) && !bus.cmd_wdata[7];
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    if (w_timeout) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_err       <= 1'b1;
                        r_ack       <= 1'b0;
                        r_rdata     <= 8'd0;
                        r_busy      <= 1'b0;
                        r_sda_oe    <= 1'b0;
                        r_scl_oe    <= 1'b0;
                    end else if (!w_cnt_done) begin
                        r_qcnt <= r_qcnt + 1'b1;
                    end else if (w_q1_wait) begin
                        r_to <= r_to + 1'b1;
                    end else begin
                        r_qcnt <= '0;
                        r_to   <= '0;
                        r_q    <= r_q + 2'd1;
                        case (r_q)
                            2'd0: r_scl_oe <= 1'b0;
                            2'd1: if (r_state == S_START) r_sda_oe <= 1'b1;
                            2'd2: begin
                                if (r_state == S_STOP) r_sda_oe <= 1'b0;
                                else                   r_scl_oe <= 1'b1;
                                if (r_state == S_BIT) begin
                                    if (r_slot[3]) r_ack_cap <= ~w_sda;
                                    else           r_sh      <= {r_sh[6:0], w_sda};
                                end
                            end
                            default: if (r_state == S_BIT && !r_slot[3]) begin
                                r_slot <= r_slot + 4'd1;
                                if (r_slot == 4'd7) r_sda_oe <= (r_op == OP_READ) && !r_nack;
                                else                r_sda_oe <= (r_op == OP_WRITE) && !r_sh[7];
                            end else begin
                                r_state     <= S_DONE;
                                r_rsp_valid <= 1'b1;
                                r_err       <= 1'b0;
                                r_busy      <= (r_state != S_STOP);
                                r_ack       <= (r_state == S_BIT && r_op == OP_WRITE) ? r_ack_cap : 1'b0;
                                r_rdata     <= (r_state == S_BIT && r_op == OP_READ) ? r_sh : 8'd0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
